// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command/response and cyc/ack bus signals of the wb_cmd_master initiator
interface wb_cmd_master_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_we;
  logic          cmd_valid;
  logic          cmd_ready;

  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_valid;
  logic          rsp_ready;

  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic          wb_we;
  logic [DW-1:0] wb_rdata;
  logic          wb_cyc;
  logic          wb_ack;

  modport master (
    input  cmd_addr, cmd_wdata, cmd_we, cmd_valid, rsp_ready, wb_rdata, wb_ack,
    output cmd_ready, rsp_rdata, rsp_err, rsp_valid, wb_addr, wb_wdata, wb_we, wb_cyc
  );

  modport slave (
    output cmd_addr, cmd_wdata, cmd_we, cmd_valid, rsp_ready, wb_rdata, wb_ack,
    input  cmd_ready, rsp_rdata, rsp_err, rsp_valid, wb_addr, wb_wdata, wb_we, wb_cyc
  );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding cyc/ack bus initiator with timeout
module wb_cmd_master #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_cmd_master_if.master  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT);
  localparam logic          TO_EN   = (TIMEOUT != 0);

  logic [1:0]    state, state_nxt;
  logic          run;
  logic [TW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic accept, ack_hit, timeout_hit, rsp_done;

  // run keeps cmd_ready low while reset is held, even though state is already IDLE
  assign accept      = run && (state == S_IDLE) && bus.cmd_valid;
  assign ack_hit     = (state == S_BUS) && bus.wb_ack;
  assign timeout_hit = (state == S_BUS) && !bus.wb_ack && TO_EN && (cnt == '0);
  assign rsp_done    = (state == S_RSP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_BUS;
      S_BUS:  if (ack_hit || timeout_hit) state_nxt = S_RSP;
      S_RSP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = run && (state == S_IDLE);
    bus.wb_cyc    = (state == S_BUS);
    bus.rsp_valid = (state == S_RSP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.wb_addr   = addr_q;
    bus.wb_wdata  = wdata_q;
    bus.wb_we     = we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        we_q    <= bus.cmd_we;
        cnt     <= TO_LOAD;
      end else if ((state == S_BUS) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      // ack takes priority over an expiring counter in the same cycle
      if (ack_hit) begin
        rdata_q <= we_q ? '0 : bus.wb_rdata;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (rsp_done) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed bench for wb_cmd_master (TIMEOUT=4)
module tb_wb_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_cmd_master_if #(.DW(16), .AW(16)) bus ();

  wb_cmd_master #(.DW(16), .AW(16), .TIMEOUT(4), .TW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] srdata;
    int          ack_at;
    int          exp_cyc;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n;
    logic fields_ok;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_pre"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_we    = v.we;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_we    = ~v.we;
    n = 0;
    fields_ok = 1'b1;
    while (bus.wb_cyc && n < 20) begin
      if (bus.wb_addr !== v.addr || bus.wb_wdata !== v.wdata || bus.wb_we !== v.we)
        fields_ok = 1'b0;
      bus.wb_ack   = (n == v.ack_at);
      bus.wb_rdata = (n == v.ack_at) ? v.srdata : 16'h0;
      n++;
      tick();
      bus.wb_ack   = 1'b0;
      bus.wb_rdata = 16'h0;
    end
    check({tag, "_cyc_cycles"}, 32'(n), 32'(v.exp_cyc));
    check({tag, "_fields"}, 32'(fields_ok), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_clear"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0);
    check({tag, "_ready_post"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] b2b_addr[8];
    logic        b2b_we[8];
    logic [15:0] b2b_exp[8];
    int sent, got, last_cyc;
    logic accept;
    logic stable_ok;

    vecs[0] = '{1'b0, 16'h1234, 16'h0000, 16'hBEEF, 2, 3, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 16'h0010, 16'hA5A5, 16'hFFFF, 0, 1, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 16'h0F0F, 16'h0000, 16'h7777, -1, 5, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 16'h0F0F, 16'h0000, 16'h1357, 4, 5, 16'h1357, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h5A5A, 16'h9999, 4, 5, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 16'hFFFE, 16'h0000, 16'h0001, 1, 2, 16'h0001, 1'b0};

    bus.cmd_addr = 16'h0; bus.cmd_wdata = 16'h0; bus.cmd_we = 1'b0; bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0; bus.wb_rdata = 16'h0; bus.wb_ack = 1'b0;

    repeat (2) tick();
    check("reset_outputs", {bus.cmd_ready, bus.wb_cyc, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0);
    check("reset_wb_fields", {bus.wb_we, bus.wb_addr}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // backpressure with stray acks while a response waits
    bus.cmd_valid = 1'b1; bus.cmd_addr = 16'h0042; bus.cmd_we = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.wb_ack = 1'b1; bus.wb_rdata = 16'h4242;
    tick();
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wb_ack = i[0]; bus.wb_rdata = 16'hDEAD;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h4242 || bus.rsp_err !== 1'b0 ||
          bus.cmd_ready !== 1'b0 || bus.wb_cyc !== 1'b0)
        stable_ok = 1'b0;
      tick();
    end
    bus.wb_ack = 1'b0; bus.wb_rdata = 16'h0;
    check("bp_stable", 32'(stable_ok), 32'd1);
    check("bp_rdata_end", 32'(bus.rsp_rdata), 32'h4242);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_release_ready", {bus.cmd_ready, bus.rsp_valid}, 32'h2);

    // asynchronous reset in the middle of a bus cycle
    bus.cmd_valid = 1'b1; bus.cmd_addr = 16'h0ABC; bus.cmd_we = 1'b1; bus.cmd_wdata = 16'h1111;
    tick();
    bus.cmd_valid = 1'b0;
    check("mid_cyc_active", 32'(bus.wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {bus.wb_cyc, bus.rsp_valid, bus.cmd_ready, bus.rsp_err}, 32'h0);
    check("async_rst_addr", {bus.wb_we, bus.wb_addr}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_release", {bus.cmd_ready, bus.rsp_valid, bus.wb_cyc}, 32'h4);
    run_txn(vecs[0], "post_rst");

    // back-to-back zero-wait transactions with rsp_ready held
    for (int i = 0; i < 8; i++) begin
      b2b_addr[i] = 16'($urandom);
      b2b_we[i]   = 1'($urandom);
      b2b_exp[i]  = b2b_we[i] ? 16'h0 : (b2b_addr[i] ^ 16'hC3C3);
    end
    sent = 0; got = 0; last_cyc = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 100 && got < 8; c++) begin
      bus.cmd_valid = (sent < 8);
      bus.cmd_addr  = b2b_addr[sent % 8];
      bus.cmd_wdata = ~b2b_addr[sent % 8];
      bus.cmd_we    = b2b_we[sent % 8];
      bus.wb_ack    = bus.wb_cyc;
      bus.wb_rdata  = bus.wb_cyc ? (bus.wb_addr ^ 16'hC3C3) : 16'h0;
      if (bus.rsp_valid) begin
        check($sformatf("b2b%0d_rdata", got), {bus.rsp_err, 15'h0, bus.rsp_rdata}, {17'h0, b2b_exp[got]});
        if (got > 0) check($sformatf("b2b%0d_spacing", got), 32'(c - last_cyc), 32'd3);
        last_cyc = c;
        got++;
      end
      accept = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (accept) sent++;
    end
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; bus.wb_ack = 1'b0; bus.wb_rdata = 16'h0;
    check("b2b_count", 32'(got), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
